// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised data-memory stage with a valid/ready request
// and a one-cycle response pulse after a configurable latency.
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (accept = valid && ready)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : 0 byte, 1 half, 2 word, 3 double
//   req_unsigned        : zero-extend loads when set
//   req_wdata           : store data, right-justified
//   resp_valid          : one-cycle response pulse (state == RESP)
//   resp_rdata/resp_err : registered load data / fault flag, held until next response
//   busy                : controller not idle
module data_mem_ctrl #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int OFFW     = $clog2(BYTES);
  localparam int IDXW     = XLEN - OFFW;
  localparam int MEMAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CNT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [XLEN-1:0] mem [0:DEPTH-1];

  state_t          state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic            enter_resp;
  logic            accept;

  logic            q_we, q_uns;
  logic [XLEN-1:0] q_addr, q_wdata;
  logic [1:0]      q_size;

  logic            c_we, c_uns;
  logic [XLEN-1:0] c_addr, c_wdata;
  logic [1:0]      c_size;

  logic [OFFW-1:0] c_off, amask;
  logic [IDXW-1:0] c_idx;
  logic            err;
  logic [XLEN-1:0] word, shifted, lmask, field, msb, ld_val;
  logic [XLEN-1:0] wmask, wsh, st_val;
  logic            sgn;
  int unsigned     nb, nbytes, off_i;

  assign req_ready  = (state != WAIT);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  // Reset gates acceptance so a request held during reset is ignored.
  assign accept     = req_valid && req_ready && reset_n;

  // With zero latency the access completes on the accept edge itself, so it
  // must work from the live request rather than the captured copy.
  always_comb begin
    if (LATENCY == 0) begin
      c_we = req_we; c_uns = req_unsigned; c_addr = req_addr;
      c_wdata = req_wdata; c_size = req_size;
    end else begin
      c_we = q_we; c_uns = q_uns; c_addr = q_addr;
      c_wdata = q_wdata; c_size = q_size;
    end
  end

  // Address decode and fault detection
  always_comb begin
    c_off = c_addr[OFFW-1:0];
    c_idx = c_addr[XLEN-1:OFFW];
    amask = OFFW'((32'd1 << c_size) - 32'd1);
    err   = (|(c_off & amask))
          || (c_idx >= IDXW'(DEPTH))
          || ((XLEN == 32) && (c_size == 2'd3));
    word  = mem[c_idx[MEMAW-1:0]];
  end

  // Load extraction: mask to the access width, then extend from its top bit.
  always_comb begin
    nb      = 32'd8 << c_size;
    shifted = word >> {c_off, 3'b000};
    if (nb >= 32'(XLEN)) lmask = '1;
    else                 lmask = (XLEN'(1) << nb) - XLEN'(1);
    field  = shifted & lmask;
    msb    = lmask & ~(lmask >> 1);
    sgn    = |(shifted & msb);
    ld_val = (sgn && !c_uns) ? (field | ~lmask) : field;
  end

  // Store merge: replace only the addressed byte lanes.
  always_comb begin
    off_i  = 32'(c_off);
    nbytes = 32'd1 << c_size;
    wmask  = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if ((k >= off_i) && (k < off_i + nbytes)) wmask[8*k +: 8] = 8'hFF;
    end
    wsh    = c_wdata << {c_off, 3'b000};
    st_val = (word & ~wmask) | (wsh & wmask);
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (state == RESP) state_n = IDLE;
        if (accept) begin
          if (LATENCY == 0) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNTW'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - CNTW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      q_we       <= 1'b0;
      q_uns      <= 1'b0;
      q_addr     <= '0;
      q_wdata    <= '0;
      q_size     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        q_we    <= req_we;
        q_uns   <= req_unsigned;
        q_addr  <= req_addr;
        q_wdata <= req_wdata;
        q_size  <= req_size;
      end
      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= (err || c_we) ? '0 : ld_val;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && c_we && !err) mem[c_idx[MEMAW-1:0]] <= st_val;
  end

endmodule
